// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register for a 5-stage RV32I
// pipeline. The block owns the fetch PC (PCF) and talks to instruction memory
// over a req/ready + rvalid handshake. Memory latency is variable, and only
// one request is ever outstanding. Execute-stage redirects (branch, jal,
// jalr) take priority over every other event. A response can land while
// Decode is stalled; it is then parked in a one-entry hold buffer.
//
// Optional feature: define FETCH_PERF_EN to build the perf_fetched and
// perf_dropped counters. When FETCH_PERF_EN is undefined, both ports are
// tied to zero and no counter flops exist.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   StallD, FlushD      hold / bubble the IF/ID register (flush wins)
//   PCSrcE, PCJalSrcE   redirect request and jalr-vs-branch target select
//   PCTargetE           branch/jal target
//   ALUResultE          jalr target (bit 0 is cleared here)
//   imem_req/addr       request to instruction memory (addr = PCF)
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   in-order response, one per accepted request
//   InstrD, PCD,        IF/ID contents presented to Decode
//   PCPlus4D, ValidD
//   perf_fetched        responses accepted into the pipeline
//   perf_dropped        responses discarded because of a redirect
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic            PCJalSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
);

    typedef enum logic [2:0] {
        S_IDLE,   // one settling cycle after reset
        S_REQ,    // request presented, waiting for imem_ready
        S_WAIT,   // request accepted, waiting for imem_rvalid
        S_HOLD,   // response buffered while Decode is stalled
        S_DROP    // outstanding response must be thrown away
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     hold_instr_q;
    logic [XLEN-1:0] hold_pc_q;
    logic            load_hold;
    logic            deliver;
    logic [31:0]     deliver_instr;
    logic [XLEN-1:0] deliver_pc;
    logic [XLEN-1:0] redirect_target;

    // jalr targets come from the ALU and must have bit 0 cleared.
    assign redirect_target = PCJalSrcE ? {ALUResultE[XLEN-1:1], 1'b0} : PCTargetE;

    // The request is a pure function of state, so it cannot glitch
    // combinationally with imem_ready. This keeps req/addr stable while
    // the memory stalls.
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;

    // -----------------------------------------------------------------------
    // Next-state / PC logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        load_hold     = 1'b0;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        deliver_pc    = pc_q;

        unique case (state_q)
            S_IDLE: state_d = S_REQ;

            S_REQ: begin
                if (PCSrcE) begin
                    pc_d = redirect_target;
                    // Once the old address is accepted, its response is stale.
                    state_d = imem_ready ? S_DROP : S_REQ;
                end else if (imem_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (PCSrcE) begin
                    pc_d    = redirect_target;
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    pc_d = pc_q + PC_STEP;
                    if (StallD) begin
                        load_hold = 1'b1;
                        state_d   = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end

            S_HOLD: begin
                if (PCSrcE) begin
                    pc_d    = redirect_target;
                    state_d = S_REQ;
                end else if (!StallD) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_instr_q;
                    deliver_pc    = hold_pc_q;
                    state_d       = S_REQ;
                end
            end

            S_DROP: begin
                if (PCSrcE) begin
                    pc_d = redirect_target;
                end
                // The stale response ends DROP even when a new redirect lands
                // in the same cycle. Otherwise the stage would wait for a
                // response that never comes.
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State and PC registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // NOTE: the hold buffer is data-only. Its validity is encoded by S_HOLD,
    // so it needs no reset and stays a plain enable flop.
    always_ff @(posedge clock) begin
        if (load_hold) begin
            hold_instr_q <= imem_rdata;
            hold_pc_q    <= pc_q;
        end
    end

    // -----------------------------------------------------------------------
    // IF/ID pipeline register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (StallD) begin
            // hold contents
        end else if (deliver) begin
            InstrD   <= deliver_instr;
            PCD      <= deliver_pc;
            PCPlus4D <= deliver_pc + PC_STEP;
            ValidD   <= 1'b1;
        end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Optional performance counters
    // -----------------------------------------------------------------------
`ifdef FETCH_PERF_EN
    logic accept_evt;
    logic drop_evt;

    // An accepted response is counted once, when it leaves WAIT. The later
    // drain from the hold buffer is the same instruction.
    assign accept_evt = (state_q == S_WAIT) && imem_rvalid && !PCSrcE;
    assign drop_evt   = ((state_q == S_WAIT) && imem_rvalid && PCSrcE)
                      || ((state_q == S_HOLD) && PCSrcE)
                      || ((state_q == S_DROP) && imem_rvalid);

    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (accept_evt) perf_fetched <= perf_fetched + 32'd1;
            if (drop_evt)   perf_dropped <= perf_dropped + 32'd1;
        end
    end
`else
    assign perf_fetched = '0;
    assign perf_dropped = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage. Instruction memory is modelled by hand
// inside each scenario task. Inputs change 1 ns after a rising edge, and
// outputs are checked at that same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        StallD, FlushD, PCSrcE, PCJalSrcE;
    logic [31:0] PCTargetE, ALUResultE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic [31:0] perf_fetched, perf_dropped;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clock       (clock),
        .reset       (reset),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .PCSrcE      (PCSrcE),
        .PCJalSrcE   (PCJalSrcE),
        .PCTargetE   (PCTargetE),
        .ALUResultE  (ALUResultE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD),
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory model for one transaction. The DUT must be in REQ with
    // imem_ready=1. The response is returned on the following cycle.
    task automatic serve(input logic [31:0] data);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCJalSrcE = 1'b0;
        PCTargetE = '0; ALUResultE = '0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%h exp=0", imem_req); end
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid got=%h exp=0", ValidD); end
        checks++; if (InstrD !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", InstrD, NOP); end
        checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL reset_pcd got=%h exp=0", PCD); end
        checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pcp4 got=%h exp=0", PCPlus4D); end
        checks++; if (perf_dropped !== 32'h0) begin errors++; $display("FAIL reset_perf got=%h exp=0", perf_dropped); end
        reset = 1'b1;
        tick();  // IDLE -> REQ
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL start_req got=%h exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL start_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_basic_fetch();
        tick();  // accepted -> WAIT
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_req got=%h exp=0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL basic_valid got=%h exp=1", ValidD); end
        checks++; if (InstrD !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got=%h exp=00500093", InstrD); end
        checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL basic_pcd got=%h exp=0", PCD); end
        checks++; if (PCPlus4D !== 32'h4) begin errors++; $display("FAIL basic_pcp4 got=%h exp=4", PCPlus4D); end
        checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin errors++; $display("FAIL basic_next got=%h/%h exp=4/1", imem_addr, imem_req); end
        serve(32'h0010_0113);  // addr 4
        checks++; if (InstrD !== 32'h0010_0113 || PCD !== 32'h4) begin errors++; $display("FAIL second_instr got=%h@%h exp=00100113@4", InstrD, PCD); end
    endtask

    task automatic test_ready_stall();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL ready_hold got=%h/%h exp=1/8 cyc=%0d", imem_req, imem_addr, i); end
            checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL ready_novalid got=%h exp=0 cyc=%0d", ValidD, i); end
        end
        imem_ready = 1'b1;
        serve(32'h0020_0193);
        checks++; if (ValidD !== 1'b1 || InstrD !== 32'h0020_0193) begin errors++; $display("FAIL ready_instr got=%h/%h exp=1/00200193", ValidD, InstrD); end
        checks++; if (PCD !== 32'h8 || PCPlus4D !== 32'hc) begin errors++; $display("FAIL ready_pc got=%h/%h exp=8/c", PCD, PCPlus4D); end
    endtask

    task automatic test_stall_hold();
        tick();  // addr 0xc accepted; IF/ID is not stalled yet, so it bubbles
        StallD = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0030_0213;
        tick();  // response buffered, IF/ID held
        imem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got=%h exp=0 cyc=%0d", imem_req, i); end
            checks++; if (ValidD !== 1'b0 || InstrD !== NOP) begin errors++; $display("FAIL hold_ifid got=%h/%h exp=0/%h cyc=%0d", ValidD, InstrD, NOP, i); end
            if (i == 0) tick();
        end
        StallD = 1'b0;
        tick();
        checks++; if (ValidD !== 1'b1 || InstrD !== 32'h0030_0213) begin errors++; $display("FAIL drain_instr got=%h/%h exp=1/00300213", ValidD, InstrD); end
        checks++; if (PCD !== 32'hc || PCPlus4D !== 32'h10) begin errors++; $display("FAIL drain_pc got=%h/%h exp=c/10", PCD, PCPlus4D); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL drain_next got=%h/%h exp=1/10", imem_req, imem_addr); end
        // Stall while a valid instruction sits in IF/ID: it must be held.
        StallD = 1'b1; imem_ready = 1'b0;
        tick();
        checks++; if (ValidD !== 1'b1 || InstrD !== 32'h0030_0213) begin errors++; $display("FAIL stall_keep got=%h/%h exp=1/00300213", ValidD, InstrD); end
        StallD = 1'b0;
    endtask

    task automatic test_branch_redirect();
        // Redirect in REQ, not accepted: stay in REQ at the new PC.
        PCSrcE = 1'b1; PCTargetE = 32'h20;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin errors++; $display("FAIL redir_req got=%h/%h exp=1/20", imem_req, imem_addr); end
        PCSrcE = 1'b0; imem_ready = 1'b1;
        tick();  // 0x20 accepted -> WAIT
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        tick();  // WAIT, no rvalid -> DROP
        PCSrcE = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_req got=%h exp=0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hbad0_0001;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL branch_addr got=%h/%h exp=1/100", imem_req, imem_addr); end
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL branch_discard got=%h exp=0", ValidD); end
        checks++; if (perf_dropped !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL branch_perf got=%0d exp=%0d", perf_dropped, PERF ? 1 : 0); end
    endtask

    task automatic test_jalr_redirect();
        tick();  // 0x100 accepted -> WAIT
        PCSrcE = 1'b1; PCJalSrcE = 1'b1; ALUResultE = 32'h205; PCTargetE = 32'hdead_beef;
        imem_rvalid = 1'b1; imem_rdata = 32'hbad0_0002;
        tick();  // WAIT + rvalid + redirect -> REQ
        PCSrcE = 1'b0; PCJalSrcE = 1'b0; imem_rvalid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin errors++; $display("FAIL jalr_addr got=%h/%h exp=1/204", imem_req, imem_addr); end
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL jalr_discard got=%h exp=0", ValidD); end
        // Redirect in the same cycle the request is accepted -> DROP.
        PCSrcE = 1'b1; PCTargetE = 32'h300;
        tick();
        PCSrcE = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL accredir_req got=%h exp=0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hbad0_0003;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL accredir_addr got=%h/%h exp=1/300", imem_req, imem_addr); end
        checks++; if (perf_dropped !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL jalr_perf got=%0d exp=%0d", perf_dropped, PERF ? 3 : 0); end
    endtask

    task automatic test_pc_wrap();
        imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'hffff_fffc;
        tick();
        PCSrcE = 1'b0; imem_ready = 1'b1;
        checks++; if (imem_addr !== 32'hffff_fffc) begin errors++; $display("FAIL wrap_req got=%h exp=fffffffc", imem_addr); end
        serve(32'h0000_0033);
        checks++; if (PCD !== 32'hffff_fffc || PCPlus4D !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h/%h exp=fffffffc/0", PCD, PCPlus4D); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%h exp=0", imem_addr); end
        checks++; if (perf_fetched !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL wrap_perf got=%0d exp=%0d", perf_fetched, PERF ? 5 : 0); end
    endtask

    task automatic test_reset_mid_wait();
        tick();  // addr 0 accepted -> WAIT
        reset = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0 || ValidD !== 1'b0) begin errors++; $display("FAIL midrst_ctl got=%h/%h exp=0/0", imem_req, ValidD); end
        checks++; if (PCD !== 32'h0 || InstrD !== NOP) begin errors++; $display("FAIL midrst_ifid got=%h/%h exp=0/%h", PCD, InstrD, NOP); end
        checks++; if (perf_fetched !== 32'h0) begin errors++; $display("FAIL midrst_perf got=%0d exp=0", perf_fetched); end
        reset = 1'b1;
        tick();  // IDLE -> REQ
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL restart got=%h/%h exp=1/0", imem_req, imem_addr); end
        serve(32'h00a0_0113);
        checks++; if (ValidD !== 1'b1 || PCD !== 32'h0) begin errors++; $display("FAIL restart_instr got=%h/%h exp=1/0", ValidD, PCD); end
        // Flush and stall together: the flush must win and bubble IF/ID.
        StallD = 1'b1; FlushD = 1'b1;
        tick();
        checks++; if (ValidD !== 1'b0 || InstrD !== NOP) begin errors++; $display("FAIL flush_wins got=%h/%h exp=0/%h", ValidD, InstrD, NOP); end
        imem_rvalid = 1'b1; imem_rdata = 32'h00b0_0193;
        tick();  // stalled -> HOLD
        imem_rvalid = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        checks++; if (imem_req !== 1'b0 || ValidD !== 1'b0) begin errors++; $display("FAIL flush_hold got=%h/%h exp=0/0", imem_req, ValidD); end
        tick();
        checks++; if (ValidD !== 1'b1 || InstrD !== 32'h00b0_0193) begin errors++; $display("FAIL flush_drain got=%h/%h exp=1/00b00193", ValidD, InstrD); end
        checks++; if (PCD !== 32'h4 || PCPlus4D !== 32'h8 || imem_addr !== 32'h8) begin errors++; $display("FAIL flush_pc got=%h/%h/%h exp=4/8/8", PCD, PCPlus4D, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_ready_stall();
        test_stall_hold();
        test_branch_redirect();
        test_jalr_redirect();
        test_pc_wrap();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I pipeline.
- Holds the PC and talks to instruction memory over a req/ready, rvalid handshake with variable latency and one request outstanding.
- Applies Execute-stage redirects (branch, jal, jalr) and presents InstrD, PCD, PCPlus4D and ValidD to Decode, where the controller consumes the op/funct3/funct7b5 fields.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on InstrD when invalid.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- StallD  input  1  hold IF/ID contents.
- FlushD  input  1  replace IF/ID contents with bubble; wins over StallD.
- PCSrcE  input  1  taken branch/jump in Execute.
- PCJalSrcE  input  1  redirect is jalr (target from ALU).
- PCTargetE  input  XLEN  branch/jal target.
- ALUResultE  input  XLEN  jalr target (bit 0 cleared by this block).
- imem_req  output  1  request valid.
- imem_addr  output  XLEN  request address (= PCF).
- imem_ready  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  response valid (exactly one per accepted request, in order).
- imem_rdata  input  32  response instruction.
- InstrD  output  32  instruction to Decode.
- PCD  output  XLEN  PC of InstrD.
- PCPlus4D  output  XLEN  PCD+4.
- ValidD  output  1  InstrD is a real instruction.
- perf_fetched  output  32  accepted-instruction count (optional feature).
- perf_dropped  output  32  discarded-response count (optional feature).

Behaviour:
- Reset (reset=0 at posedge):
  - PCF=RESET_PC, state=IDLE, hold buffer empty.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, imem_req=0.
  - Instruction memory shares this reset; no response is delivered for a request outstanding at reset.
- States:
  - IDLE: one cycle after reset, then REQ.
  - REQ: imem_req=1, imem_addr=PCF. On ready → WAIT.
  - WAIT: request outstanding; imem_req=0.
  - HOLD: response buffered while Decode is stalled; imem_req=0.
  - DROP: outstanding response is to be discarded; imem_req=0.
- Redirect target: PCJalSrcE ? {ALUResultE[XLEN-1:1],1'b0} : PCTargetE. Redirect has priority over all other events.
  - REQ, not accepted: PCF<=target, stay REQ.
  - REQ, accepted same cycle: PCF<=target, → DROP.
  - WAIT, no rvalid: PCF<=target, → DROP.
  - WAIT with rvalid same cycle: data discarded, PCF<=target, → REQ.
  - HOLD: buffer discarded, PCF<=target, → REQ.
  - DROP: PCF<=target, stay DROP.
- DROP with rvalid: discard data, → REQ.
- WAIT with rvalid and no redirect: PCF<=PCF+4 (wraps modulo 2^XLEN).
  - StallD=0: load IF/ID, → REQ.
  - StallD=1: store {rdata, PC} in hold buffer, → HOLD.
- HOLD with StallD=0: transfer buffer to IF/ID, → REQ.
- IF/ID update each posedge:
  - FlushD=1: bubble (ValidD=0, InstrD=NOP_INSTR; PCD and PCPlus4D hold).
  - Else StallD=1: hold.
  - Else if an instruction is delivered (rvalid accepted in WAIT, or HOLD drain): load InstrD, PCD, PCPlus4D=PCD+4, ValidD=1.
  - Else: bubble.
- Latency: fetch-to-ValidD is at least 2 cycles after imem_req. Throughput is one instruction per 2 cycles with 1-cycle memory.
- Exactly one request is outstanding at any time; imem_req is never asserted in WAIT, HOLD or DROP.
- imem_req/imem_addr stay stable while imem_req=1 && imem_ready=0, unless a redirect occurs.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - perf_fetched increments on each instruction loaded into IF/ID or the hold buffer.
  - perf_dropped increments on each response discarded (DROP, WAIT+redirect, HOLD+redirect).
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- Reset release, imem 1-cycle latency, rdata=32'h00500093 at addr 0 → imem_addr=0 on cycle 2; ValidD=1, InstrD=32'h00500093, PCD=0, PCPlus4D=4 on cycle 4; next imem_addr=4.
- imem_ready held low 3 cycles at addr 8 → imem_req stays 1, imem_addr stays 8; no ValidD until accepted.
- Response arrives with StallD=1 for 2 cycles → state HOLD, no new imem_req, ValidD/InstrD unchanged; StallD drop → IF/ID loads buffered instr, next req at PC+4.
- PCSrcE=1, PCTargetE=32'h100 while WAIT at addr 0x20 → response discarded, next imem_addr=32'h100, perf_dropped=1 (FETCH_PERF_EN).
- jalr redirect PCJalSrcE=1, ALUResultE=32'h205 → imem_addr=32'h204.
- reset=0 asserted mid-WAIT → next cycle all outputs at reset values, imem_req=0, then restart from RESET_PC; FlushD and StallD both 1 → ValidD=0.
